// File: rtl/radar_pkg.sv
// ============================================================================
// radar_pkg : shared defaults, widths and LFSR helper for the radar source.
// Rev 1.0
// ============================================================================
`default_nettype none

package radar_pkg;

  localparam int DEF_PRI_CYCLES     = 2500;
  localparam int DEF_TRIG_WIDTH     = 50;
  localparam int DEF_PULSES_PER_ACP = 4;
  localparam int DEF_ACP_PER_REV    = 4096;
  localparam int DEF_ACP_WIDTH      = 25;
  localparam int DEF_SAMPLE_DIV     = 5;
  localparam int DEF_GAIN_STEP      = 8;
  localparam int DEF_GAIN_FLOOR     = 64;
  localparam logic [31:0] DEF_LFSR_SEED = 32'hACE1_2468;

  localparam int GAIN_W  = 12;
  localparam int VIDEO_W = 12;
  localparam int LFSR_W  = 32;

  localparam logic [LFSR_W-1:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [GAIN_W-1:0] GAIN_MAX  = '1;

  typedef logic [LFSR_W-1:0] lfsr_t;

  typedef struct packed {
    logic trig;
    logic acp;
    logic arp;
  } timing_t;

  // Galois form of x^32+x^22+x^2+x+1, shifting right.
  function automatic lfsr_t lfsr_step(input lfsr_t s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/radar_clutter_gen.sv
// ============================================================================
// radar_clutter_gen : LFSR noise scaled by a range-decaying gain.
// Rev 1.0
// ============================================================================
`default_nettype none

module radar_clutter_gen
  import radar_pkg::*;
#(
  parameter int          GAIN_STEP  = DEF_GAIN_STEP,
  parameter int          GAIN_FLOOR = DEF_GAIN_FLOOR,
  parameter logic [31:0] LFSR_SEED  = DEF_LFSR_SEED
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               blank,
  input  logic               tick,
  output logic [VIDEO_W-1:0] video
);

  localparam logic [GAIN_W-1:0] STEP       = GAIN_W'(GAIN_STEP);
  localparam logic [GAIN_W-1:0] FLOOR      = GAIN_W'(GAIN_FLOOR);
  localparam logic [GAIN_W-1:0] FLOOR_STEP = GAIN_W'(GAIN_FLOOR + GAIN_STEP);

  lfsr_t                 lfsr_q, lfsr_d, lfsr_nx;
  logic [GAIN_W-1:0]     gain_q, gain_d;
  logic [VIDEO_W-1:0]    video_q, video_d;
  logic [2*GAIN_W-1:0]   prod;

  always_comb begin
    lfsr_d  = lfsr_q;
    gain_d  = gain_q;
    video_d = video_q;
    lfsr_nx = lfsr_step(lfsr_q);
    prod    = {{GAIN_W{1'b0}}, lfsr_nx[GAIN_W-1:0]} * {{GAIN_W{1'b0}}, gain_q};
    if (blank) begin
      video_d = '0;
      gain_d  = GAIN_MAX;
    end else if (tick) begin
      lfsr_d  = lfsr_nx;
      video_d = VIDEO_W'(prod >> GAIN_W);
      // Saturate at the noise floor instead of wrapping below zero.
      gain_d  = (gain_q >= FLOOR_STEP) ? (gain_q - STEP) : FLOOR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q  <= LFSR_SEED;
      gain_q  <= GAIN_MAX;
      video_q <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      gain_q  <= gain_d;
      video_q <= video_d;
    end
  end

  assign video = video_q;

endmodule

`default_nettype wire

// File: rtl/radar.sv
// ============================================================================
// radar : synthetic marine-radar source (trig/acp/arp timing + clutter video).
// Rev 1.0
// ============================================================================
`default_nettype none

module radar
  import radar_pkg::*;
#(
  parameter int          PRI_CYCLES     = DEF_PRI_CYCLES,
  parameter int          TRIG_WIDTH     = DEF_TRIG_WIDTH,
  parameter int          PULSES_PER_ACP = DEF_PULSES_PER_ACP,
  parameter int          ACP_PER_REV    = DEF_ACP_PER_REV,
  parameter int          ACP_WIDTH      = DEF_ACP_WIDTH,
  parameter int          SAMPLE_DIV     = DEF_SAMPLE_DIV,
  parameter int          GAIN_STEP      = DEF_GAIN_STEP,
  parameter int          GAIN_FLOOR     = DEF_GAIN_FLOOR,
  parameter logic [31:0] LFSR_SEED      = DEF_LFSR_SEED
) (
  input  logic               clk,
  input  logic               rst,
  output logic               arp,
  output logic               acp,
  output logic               trig,
  output logic [VIDEO_W-1:0] video
);

  localparam int PRI_W   = (PRI_CYCLES > 1)     ? $clog2(PRI_CYCLES)     : 1;
  localparam int PULSE_W = (PULSES_PER_ACP > 1) ? $clog2(PULSES_PER_ACP) : 1;
  localparam int ACPC_W  = (ACP_PER_REV > 1)    ? $clog2(ACP_PER_REV)    : 1;
  localparam int DIV_W   = (SAMPLE_DIV > 1)     ? $clog2(SAMPLE_DIV)     : 1;

  localparam logic [PRI_W-1:0]   PRI_LAST   = PRI_W'(PRI_CYCLES - 1);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSES_PER_ACP - 1);
  localparam logic [ACPC_W-1:0]  ACPC_LAST  = ACPC_W'(ACP_PER_REV - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SAMPLE_DIV - 1);

  logic [PRI_W-1:0]   pri_cnt_q, pri_cnt_d;
  logic [PULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [ACPC_W-1:0]  acp_cnt_q, acp_cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  timing_t            timing_q, timing_d;

  logic pri_wrap, pulse_wrap, acp_wrap;
  logic blank, tick, acp_cond;

  always_comb begin
    pri_wrap   = (pri_cnt_q == PRI_LAST);
    pulse_wrap = (pulse_cnt_q == PULSE_LAST);
    acp_wrap   = (acp_cnt_q == ACPC_LAST);

    pri_cnt_d   = pri_wrap ? '0 : pri_cnt_q + PRI_W'(1);
    pulse_cnt_d = pulse_cnt_q;
    acp_cnt_d   = acp_cnt_q;
    if (pri_wrap) begin
      pulse_cnt_d = pulse_wrap ? '0 : pulse_cnt_q + PULSE_W'(1);
      if (pulse_wrap)
        acp_cnt_d = acp_wrap ? '0 : acp_cnt_q + ACPC_W'(1);
    end

    blank    = (int'(pri_cnt_q) < TRIG_WIDTH);
    acp_cond = (pulse_cnt_q == '0) && (int'(pri_cnt_q) < ACP_WIDTH);

    timing_d.trig = blank;
    timing_d.acp  = acp_cond;
    timing_d.arp  = acp_cond && (acp_cnt_q == '0);

    // Divider parks at 0 during the trigger so the first tick lands on TRIG_WIDTH.
    tick  = !blank && (div_q == '0);
    div_d = '0;
    if (!blank)
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pri_cnt_q   <= '0;
      pulse_cnt_q <= '0;
      acp_cnt_q   <= '0;
      div_q       <= '0;
      timing_q    <= '0;
    end else begin
      pri_cnt_q   <= pri_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      acp_cnt_q   <= acp_cnt_d;
      div_q       <= div_d;
      timing_q    <= timing_d;
    end
  end

  radar_clutter_gen #(
    .GAIN_STEP  (GAIN_STEP),
    .GAIN_FLOOR (GAIN_FLOOR),
    .LFSR_SEED  (LFSR_SEED)
  ) u_clutter (
    .clk   (clk),
    .rst   (rst),
    .blank (blank),
    .tick  (tick),
    .video (video)
  );

  assign trig = timing_q.trig;
  assign acp  = timing_q.acp;
  assign arp  = timing_q.arp;

endmodule

`default_nettype wire

// File: tb/tb_radar.sv
// ============================================================================
// tb_radar : self-checking bench for radar (timing table + clutter model).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_radar;

  localparam int PRI   = 2500;
  localparam int TW    = 50;
  localparam int PPA   = 4;
  localparam int APR   = 4;     // shortened revolution so ARP repeats inside the run
  localparam int AW    = 25;
  localparam int SD    = 5;
  localparam int GSTEP = 8;
  localparam int GFLR  = 64;
  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam logic [31:0] POLY = 32'h8020_0003;
  localparam int NT    = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arp, acp, trig;
  logic [11:0] video;

  radar #(.ACP_PER_REV(APR)) dut (
    .clk   (clk),
    .rst   (rst),
    .arp   (arp),
    .acp   (acp),
    .trig  (trig),
    .video (video)
  );

  always #10 clk = ~clk;

  typedef struct {
    int   k;
    logic trig;
    logic acp;
    logic arp;
  } vec_t;

  vec_t        tbl [NT];
  int          checks = 0;
  int          fails  = 0;
  int          n;
  logic [31:0] lfsr_m;
  int          e_video, samp;
  int          gold [100];
  bit          use_tbl, gold_mode;
  logic        p_trig, p_acp, p_arp;
  int          trig_len, acp_len, last_trig_rise, last_arp_rise;

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
      if (fails >= 40) begin
        summary();
        $finish;
      end
    end
  endtask

  task automatic model_reset();
    n = 0; lfsr_m = SEED; e_video = 0; samp = 0;
    p_trig = 0; p_acp = 0; p_arp = 0;
    trig_len = 0; acp_len = 0; last_trig_rise = -1; last_arp_rise = -1;
  endtask

  task automatic run_edges(input int cnt);
    int pri, pulse, ac, s, g;
    logic et, ea, er;
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk); #1;
      pri   = n % PRI;
      pulse = (n / PRI) % PPA;
      ac    = (n / (PRI * PPA)) % APR;
      et = (pri < TW);
      ea = (pulse == 0) && (pri < AW);
      er = ea && (ac == 0);
      if (pri < TW) begin
        e_video = 0;
      end else if ((pri - TW) % SD == 0) begin
        s = (pri - TW) / SD;
        g = 4095 - GSTEP * s;
        if (g < GFLR) g = GFLR;
        lfsr_m  = lfsr_m[0] ? ((lfsr_m >> 1) ^ POLY) : (lfsr_m >> 1);
        e_video = (int'(lfsr_m[11:0]) * g) >> 12;
        check("video_le_gain", 64'(int'(video) <= g), 64'd1);
        if (samp < 100) begin
          if (gold_mode) check("gold_sample", 64'(video), 64'(gold[samp]));
          else gold[samp] = e_video;
        end
        samp++;
      end
      check("outputs", {trig, acp, arp, video}, {et, ea, er, 12'(e_video)});

      if (use_tbl)
        for (int j = 0; j < NT; j++)
          if (tbl[j].k == n + 1) begin
            check("tbl_timing", {trig, acp, arp}, {tbl[j].trig, tbl[j].acp, tbl[j].arp});
            if (tbl[j].trig) check("tbl_blank", 64'(video), 64'd0);
          end

      if (trig && !p_trig) begin
        if (last_trig_rise >= 0) check("trig_period", 64'(n - last_trig_rise), 64'(PRI));
        last_trig_rise = n;
      end
      if (!trig && p_trig) check("trig_width", 64'(trig_len), 64'(TW));
      if (!acp && p_acp)   check("acp_width", 64'(acp_len), 64'(AW));
      if (acp && !p_acp)   check("acp_on_trig_rise", 64'(trig && !p_trig), 64'd1);
      if (arp && !p_arp) begin
        check("arp_on_acp_rise", 64'(acp && !p_acp), 64'd1);
        if (last_arp_rise >= 0) check("arp_period", 64'(n - last_arp_rise), 64'(PRI * PPA * APR));
        else check("arp_first", 64'(n), 64'd0);
        last_arp_rise = n;
      end
      trig_len = trig ? trig_len + 1 : 0;
      acp_len  = acp  ? acp_len + 1  : 0;
      p_trig = trig; p_acp = acp; p_arp = arp;
      n++;
    end
  endtask

  initial begin
    tbl[0]  = '{1,     1'b1, 1'b1, 1'b1};
    tbl[1]  = '{25,    1'b1, 1'b1, 1'b1};
    tbl[2]  = '{26,    1'b1, 1'b0, 1'b0};
    tbl[3]  = '{50,    1'b1, 1'b0, 1'b0};
    tbl[4]  = '{51,    1'b0, 1'b0, 1'b0};
    tbl[5]  = '{2501,  1'b1, 1'b0, 1'b0};
    tbl[6]  = '{10001, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{10026, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{40001, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{40025, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{40026, 1'b1, 1'b0, 1'b0};

    model_reset();
    repeat (5) begin
      @(negedge clk);
      check("reset_state", {trig, acp, arp, video}, 15'd0);
    end
    rst = 1'b0;

    use_tbl = 1; gold_mode = 0;
    run_edges(45000);
    use_tbl = 0;
    run_edges($urandom_range(100, 2400));

    // Asynchronous abort mid-PRI, then restart and replay the same sequence.
    #($urandom_range(2, 7));
    rst = 1'b1;
    #1;
    check("reset_async", {trig, acp, arp, video}, 15'd0);
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", {trig, acp, arp, video}, 15'd0);
    end
    model_reset();
    rst = 1'b0;
    gold_mode = 1;
    run_edges(3000);

    summary();
    $finish;
  end

endmodule

`default_nettype wire
